// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus outgoing valid/ready stream of fifo_stream_reader.
// master = the reader, slave = the FIFO and the downstream consumer.
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_rd_o;
  logic [DATA_WIDTH-1:0] fifo_q_i;
  logic                  fifo_empty_i;
  logic                  src_valid_o;
  logic [DATA_WIDTH-1:0] src_data_o;
  logic                  src_last_o;
  logic                  src_ready_i;

  modport master (
    output fifo_rd_o,
    input  fifo_q_i,
    input  fifo_empty_i,
    output src_valid_o,
    output src_data_o,
    output src_last_o,
    input  src_ready_i
  );

  modport slave (
    input  fifo_rd_o,
    output fifo_q_i,
    output fifo_empty_i,
    input  src_valid_o,
    input  src_data_o,
    input  src_last_o,
    output src_ready_i
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO into a valid/ready stream through a
// 3-entry skid buffer, with optional fixed-length packet framing.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int PKT_LEN    = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  fifo_stream_reader_if.master bus,
  output logic [31:0]          word_cnt_o,
  output logic                 idle_o
);
  localparam logic [15:0] LAST_IDX =
    16'(PKT_LEN == 0 ? 0 : PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] mem [3];
  logic [1:0]            occ;
  logic [1:0]            wr_idx;
  logic [2:0]            load;
  logic                  inflight;
  logic                  rd;
  logic                  pop;
  logic                  at_last;
  logic [15:0]           idx;

  // Reads only count registered state, so ready never reaches fifo_rd_o.
  assign load    = {1'b0, occ} + {2'b0, inflight};
  assign rd      = ~rst_i & enable_i & ~bus.fifo_empty_i
                 & (load < 3'd3);
  assign pop     = bus.src_valid_o & bus.src_ready_i;
  assign wr_idx  = occ - {1'b0, pop};
  assign at_last = (PKT_LEN != 0) && (idx == LAST_IDX);

  assign bus.fifo_rd_o   = rd;
  assign bus.src_valid_o = (occ != 2'd0);
  assign bus.src_data_o  = mem[0];
  assign bus.src_last_o  = bus.src_valid_o & at_last;
  assign idle_o          = (occ == 2'd0) & ~inflight;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ        <= 2'd0;
      inflight   <= 1'b0;
      idx        <= 16'd0;
      word_cnt_o <= 32'd0;
      mem[0]     <= '0;
      mem[1]     <= '0;
      mem[2]     <= '0;
    end else begin
      inflight <= rd;
      occ      <= occ + {1'b0, inflight} - {1'b0, pop};
      if (pop) begin
        mem[0]     <= mem[1];
        mem[1]     <= mem[2];
        word_cnt_o <= word_cnt_o + 32'd1;
        idx        <= bus.src_last_o ? 16'd0 : idx + 16'd1;
      end
      // Tail write lands after the shift, at the post-pop position.
      if (inflight) mem[wr_idx] <= bus.fifo_q_i;
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench for fifo_stream_reader: FIFO model, queue-based
// reference of the word stream, per-cycle compare and literal pins.
module tb_fifo_stream_reader;
  localparam int DW = 16;
  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] word_cnt;
  logic        idle;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(
    .DATA_WIDTH(DW),
    .PKT_LEN   (PL)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .enable_i  (enable),
    .bus       (bus),
    .word_cnt_o(word_cnt),
    .idle_o    (idle)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [DW-1:0] src [$];
  logic [DW-1:0] exp_w [$];
  int          exp_r [$];
  logic [DW-1:0] got [$];
  logic        got_last [$];
  int          midx = 0;
  logic [31:0] mcnt = 0;
  int          ph_rd = 0;
  int          first_rd = -1;
  int          first_v = -1;
  int          rmode = 1;
  bit          tog = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // FIFO side, reference model and per-cycle compare.
  always @(posedge clk) begin : scoreboard
    logic          xfer;
    logic          rd;
    logic          e_rd;
    logic          e_v;
    logic [DW-1:0] w;
    int            e;
    xfer = bus.src_valid_o & bus.src_ready_i;
    rd   = bus.fifo_rd_o;
    e_rd = !rst && enable && !bus.fifo_empty_i && (exp_w.size() < 3);
    chk("rd_issue", 32'(rd), 32'(e_rd));
    if (rd) ph_rd++;
    if (rd && first_rd < 0) first_rd = cyc;
    if (bus.src_valid_o && first_v < 0) first_v = cyc;
    e = cyc;
    w = '0;
    if (rd && src.size() != 0) w = src.pop_front();
    if (rd) bus.fifo_q_i <= w;
    if (rst) begin
      exp_w.delete();
      exp_r.delete();
      midx = 0;
      mcnt = 0;
    end else begin
      if (xfer) begin
        tests++;
        if (exp_w.size() == 0) begin
          fails++;
          $display("FAIL spurious_xfer: data %h with no word owed",
                   bus.src_data_o);
        end else begin
          got.push_back(bus.src_data_o);
          got_last.push_back(bus.src_last_o);
          void'(exp_w.pop_front());
          void'(exp_r.pop_front());
          mcnt = mcnt + 1;
          midx = (midx == PL - 1) ? 0 : midx + 1;
        end
      end
      if (rd) begin
        exp_w.push_back(w);
        exp_r.push_back(e);
      end
    end
    cyc++;
    #1;
    // A word read before edge r is on the output after edge r+1.
    e_v = (exp_w.size() != 0) && (exp_r[0] < e);
    chk("valid", 32'(bus.src_valid_o), 32'(e_v));
    if (e_v) chk("data", 32'(bus.src_data_o), 32'(exp_w[0]));
    chk("last", 32'(bus.src_last_o), 32'(e_v && midx == PL - 1));
    chk("word_cnt", word_cnt, mcnt);
    chk("idle", 32'(idle), 32'(exp_w.size() == 0));
  end

  task automatic step();
    @(negedge clk);
    bus.fifo_empty_i = (src.size() == 0) || (tog && (cyc % 2 == 1));
    if (rmode == 2) bus.src_ready_i = 1'($urandom_range(0, 1));
    else            bus.src_ready_i = (rmode == 1);
  endtask

  task automatic wait_done(string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      done = (src.size() == 0) && (exp_w.size() == 0) && idle;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: src %0d owed %0d idle %0b",
               name, src.size(), exp_w.size(), idle);
    end
  endtask

  initial begin
    logic [9:0] lv;
    rst              = 1'b1;
    enable           = 1'b1;
    bus.src_ready_i  = 1'b1;
    bus.fifo_q_i     = '0;
    bus.fifo_empty_i = 1'b1;
    for (int i = 1; i <= 8; i++) src.push_back(DW'(i));

    repeat (5) begin
      step();
      chk("rst_rd", 32'(bus.fifo_rd_o), 32'd0);
      chk("rst_valid", 32'(bus.src_valid_o), 32'd0);
      chk("rst_cnt", word_cnt, 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
    end

    got.delete();
    first_rd = -1;
    first_v  = -1;
    rst      = 1'b0;
    wait_done("stream");
    chk("stream_latency", 32'(first_v - first_rd), 32'd2);
    chk("stream_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size(); i++)
      chk("stream_order", 32'(got[i]), 32'(i + 1));
    chk("stream_cnt", word_cnt, 32'd8);
    chk("stream_idle", 32'(idle), 32'd1);

    rmode = 0;
    got.delete();
    for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
    ph_rd = 0;
    repeat (20) step();
    chk("bp_reads", 32'(ph_rd), 32'd3);
    chk("bp_valid", 32'(bus.src_valid_o), 32'd1);
    chk("bp_head", 32'(bus.src_data_o), 32'h0001);
    rmode = 1;
    wait_done("bp");
    chk("bp_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size(); i++)
      chk("bp_order", 32'(got[i]), 32'(i + 1));
    chk("bp_cnt", word_cnt, 32'd16);

    rmode = 2;
    got.delete();
    got_last.delete();
    for (int i = 0; i < 10; i++) src.push_back(DW'(16'h0100 + i));
    wait_done("frame");
    lv = '0;
    for (int i = 0; i < got_last.size() && i < 10; i++)
      lv[i] = got_last[i];
    chk("frame_count", 32'(got_last.size()), 32'd10);
    chk("frame_last", 32'(lv), 32'h088);
    chk("frame_idx", 32'(midx), 32'd2);
    chk("frame_cnt", word_cnt, 32'd26);

    rmode = 1;
    tog   = 1'b1;
    got.delete();
    for (int i = 0; i < 12; i++) src.push_back(DW'(16'h0300 + i));
    repeat (5) step();
    enable = 1'b0;
    ph_rd  = 0;
    repeat (6) step();
    chk("en_low_reads", 32'(ph_rd), 32'd0);
    enable = 1'b1;
    wait_done("empty_en");
    tog = 1'b0;
    chk("en_count", 32'(got.size()), 32'd12);
    if (got.size() == 12)
      chk("en_tail", 32'(got[11]), 32'h030b);

    rmode = 0;
    got.delete();
    for (int i = 0; i < 6; i++) src.push_back(DW'(16'h0200 + i));
    ph_rd = 0;
    for (int i = 0; i < 20 && ph_rd < 3; i++) step();
    chk("mid_pre_valid", 32'(bus.src_valid_o), 32'd1);
    chk("mid_pre_idle", 32'(idle), 32'd0);
    rst = 1'b1;
    step();
    chk("mid_rst_valid", 32'(bus.src_valid_o), 32'd0);
    chk("mid_rst_cnt", word_cnt, 32'd0);
    chk("mid_rst_idle", 32'(idle), 32'd1);
    rst   = 1'b0;
    rmode = 1;
    wait_done("mid");
    chk("mid_count", 32'(got.size()), 32'd3);
    for (int i = 0; i < got.size(); i++)
      chk("mid_order", 32'(got[i]), 32'(16'h0203 + i));
    chk("mid_cnt", word_cnt, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
